// File: rtl/counter_ctrl_pkg.sv
// Shared constants for the counter step sequencer: FSM encoding and output widths.
package counter_ctrl_pkg;

    localparam int STATE_W = 2;
    localparam int COUNT_W = 8;

    // Encoding 2'd3 is unused and recovers to MANUAL.
    typedef enum logic [STATE_W-1:0] {
        MANUAL = 2'd0,
        RUN    = 2'd1,
        LOAD   = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output level follows
// the synchronized input only after it has differed for DEBOUNCE_CYCLES cycles in a row.
module key_debounce #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             level_reg;
    logic             level_next;

    // Any cycle where the input agrees with the accepted level restarts the count.
    always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        if (sync_reg[1] != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = sync_reg[1];
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= {2{RESET_LEVEL}};
            cnt_reg   <= '0;
            level_reg <= RESET_LEVEL;
        end else begin
            sync_reg  <= {sync_reg[0], raw};
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/counter_step_ctrl.sv
// Turns raw keys, the run switch and a divided clock into clean one-cycle load/step
// strobes for the custom-sequence counter, and keeps a tally of steps since the last load.
module counter_step_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 50000000
) (
    input  logic               CLOCK_50,
    input  logic               RST_N,
    input  logic               key_step_n,
    input  logic               key_load_n,
    input  logic               run_sw,
    input  logic [1:0]         rate_sel,
    input  logic [3:0]         load_data,
    output logic               load,
    output logic [3:0]         load_value,
    output logic               step,
    output logic [STATE_W-1:0] state,
    output logic [COUNT_W-1:0] step_count
);

    localparam int TICK_W = $clog2(TICK_DIV + 1);
    // Bit order: 0 = step key, 1 = load key, 2 = run switch.
    localparam logic [2:0] RESET_LEVELS = 3'b011;

    logic [2:0] raw_in;
    logic [2:0] deb_level;

    assign raw_in = {run_sw, key_load_n, key_step_n};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RESET_LEVEL    (RESET_LEVELS[gi])
            ) u_deb (
                .clk  (CLOCK_50),
                .rst_n(RST_N),
                .raw  (raw_in[gi]),
                .level(deb_level[gi])
            );
        end
    endgenerate

    ctrl_state_t        state_reg;
    ctrl_state_t        state_next;
    logic [1:0]         key_prev_reg;
    logic [TICK_W-1:0]  tick_cnt_reg;
    logic [TICK_W-1:0]  tick_next;
    logic               step_reg;
    logic               step_next;
    logic               load_reg;
    logic               load_next;
    logic [3:0]         load_value_reg;
    logic [COUNT_W-1:0] step_count_reg;

    logic               step_evt;
    logic               load_evt;
    logic               run_lvl;
    logic [31:0]        period_full;
    logic [TICK_W-1:0]  tick_last;
    logic               tick_term;

    // Presses are falling edges of the debounced key level; releases are ignored.
    assign step_evt = key_prev_reg[0] & ~deb_level[0];
    assign load_evt = key_prev_reg[1] & ~deb_level[1];
    assign run_lvl  = deb_level[2];

    assign period_full = 32'(TICK_DIV) >> rate_sel;
    assign tick_last   = TICK_W'(period_full - 32'd1);
    // ">=" lets a counter stranded above a newly shortened period wrap immediately.
    assign tick_term   = (tick_cnt_reg >= tick_last);

    always_comb begin
        state_next = state_reg;
        step_next  = 1'b0;
        load_next  = 1'b0;
        tick_next  = '0;
        if (load_evt) begin
            // Load pre-empts any step or tick in the same cycle; that step is lost.
            state_next = LOAD;
            load_next  = 1'b1;
        end else begin
            case (state_reg)
                MANUAL: begin
                    step_next = step_evt;
                    if (run_lvl) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (tick_term) begin
                        step_next = 1'b1;
                    end else begin
                        tick_next = tick_cnt_reg + TICK_W'(1);
                    end
                    if (!run_lvl) begin
                        state_next = MANUAL;
                        tick_next  = '0;
                    end
                end
                LOAD: begin
                    state_next = run_lvl ? RUN : MANUAL;
                end
                default: begin
                    state_next = MANUAL;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_reg      <= MANUAL;
            key_prev_reg   <= 2'b11;
            tick_cnt_reg   <= '0;
            step_reg       <= 1'b0;
            load_reg       <= 1'b0;
            load_value_reg <= '0;
            step_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            key_prev_reg <= deb_level[1:0];
            tick_cnt_reg <= tick_next;
            step_reg     <= step_next;
            load_reg     <= load_next;
            if (load_next) begin
                load_value_reg <= load_data;
                step_count_reg <= '0;
            end else if (step_next) begin
                step_count_reg <= step_count_reg + COUNT_W'(1);
            end
        end
    end

    assign load       = load_reg;
    assign load_value = load_value_reg;
    assign step       = step_reg;
    assign state      = state_reg;
    assign step_count = step_count_reg;

endmodule
